sprite_engine: RTL

SPRITE_ENGINE -- requirements
Module: sprite_engine

---
 rtl/sprite_engine_if.sv | 22 ++
 rtl/sprite_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sprite_engine_if.sv
// Video timing, attribute/sprite table read ports and pixel outputs of the sprite engine.
interface sprite_engine_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [5:0]  attr_addr;
  logic [31:0] attr_data;
  logic [9:0]  spr_addr;
  logic [31:0] spr_data;
  logic [5:0]  pix_color;
  logic        line_overflow;
  logic        frame_overflow;

  modport master (
    input  hcount, vcount, attr_data, spr_data,
    output attr_addr, spr_addr, pix_color, line_overflow, frame_overflow
  );

  modport slave (
    output hcount, vcount, attr_data, spr_data,
    input  attr_addr, spr_addr, pix_color, line_overflow, frame_overflow
  );
endinterface

// File: rtl/sprite_engine.sv
// Scanline sprite engine: evaluates next line's sprites during hblank into a pending
// slot set, commits it at end of line, and renders the active set during display.
module sprite_engine #(
  parameter int unsigned MAX_SPRITES = 4,
  parameter int unsigned NUM_ATTRS   = 64,
  parameter int unsigned SPRITE_H    = 16
) (
  input logic             clk,
  input logic             reset,
  sprite_engine_if.master bus
);
  localparam int unsigned VC_W      = $clog2(MAX_SPRITES + 1);
  localparam logic [10:0] H_EVAL    = 11'd1280;
  localparam logic [10:0] H_TMO     = 11'd1598;
  localparam logic [10:0] H_COMMIT  = 11'd1599;
  localparam logic [5:0]  LAST_ATTR = 6'(NUM_ATTRS - 1);

  typedef enum logic [2:0] {IDLE, FETCH_A, CHECK, FETCH_S, LOAD, DONE} state_t;

  state_t            state;
  logic [5:0]        ac;
  logic [VC_W-1:0]   vc;
  logic              pend_ovf;
  logic [9:0]        cur_x;
  logic [3:0]        cur_pal;

  logic [MAX_SPRITES-1:0] pend_valid, act_valid;
  logic [31:0] pend_row [MAX_SPRITES];
  logic [9:0]  pend_x   [MAX_SPRITES];
  logic [3:0]  pend_pal [MAX_SPRITES];
  logic [31:0] act_row  [MAX_SPRITES];
  logic [9:0]  act_x    [MAX_SPRITES];
  logic [3:0]  act_pal  [MAX_SPRITES];

  logic [10:0] ty, attr_y;
  logic [9:0]  row_off;
  logic        hit, evaluating;

  assign ty         = (bus.vcount == 10'd524) ? 11'd0 : {1'b0, bus.vcount} + 11'd1;
  assign attr_y     = {1'b0, bus.attr_data[9:0]};
  assign hit        = (attr_y <= ty) && (ty <= attr_y + 11'(SPRITE_H - 1));
  assign row_off    = 10'(ty - attr_y);
  assign evaluating = (state == FETCH_A) || (state == CHECK) || (state == FETCH_S) || (state == LOAD);

  // Evaluation FSM, pending/active slot sets and overflow flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      ac                 <= '0;
      vc                 <= '0;
      pend_ovf           <= 1'b0;
      cur_x              <= '0;
      cur_pal            <= '0;
      pend_valid         <= '0;
      act_valid          <= '0;
      pend_row           <= '{default: '0};
      pend_x             <= '{default: '0};
      pend_pal           <= '{default: '0};
      act_row            <= '{default: '0};
      act_x              <= '{default: '0};
      act_pal            <= '{default: '0};
      bus.attr_addr      <= '0;
      bus.spr_addr       <= '0;
      bus.line_overflow  <= 1'b0;
      bus.frame_overflow <= 1'b0;
    end else begin
      if (bus.hcount == 11'd0 && bus.vcount == 10'd0) bus.frame_overflow <= 1'b0;
      // Running out of hblank abandons the scan; an in-flight sprite is dropped
      if (evaluating && bus.hcount == H_TMO) begin
        pend_ovf <= 1'b1;
        state    <= DONE;
      end else begin
        case (state)
          IDLE: if (bus.hcount == H_EVAL) begin
            ac            <= '0;
            vc            <= '0;
            pend_ovf      <= 1'b0;
            pend_valid    <= '0;
            bus.attr_addr <= '0;
            state         <= FETCH_A;
          end
          FETCH_A: state <= CHECK;
          CHECK: begin
            if (hit) begin
              if (vc == VC_W'(MAX_SPRITES)) begin
                pend_ovf <= 1'b1;
                state    <= DONE;
              end else begin
                cur_x        <= bus.attr_data[19:10];
                cur_pal      <= bus.attr_data[31:28];
                bus.spr_addr <= 10'(bus.attr_data[27:20]) + row_off;
                state        <= FETCH_S;
              end
            end else if (ac == LAST_ATTR) begin
              state <= DONE;
            end else begin
              ac            <= ac + 6'd1;
              bus.attr_addr <= ac + 6'd1;
              state         <= FETCH_A;
            end
          end
          FETCH_S: state <= LOAD;
          LOAD: begin
            for (int i = 0; i < int'(MAX_SPRITES); i++) begin
              if (vc == VC_W'(i)) begin
                pend_row[i]   <= bus.spr_data;
                pend_x[i]     <= cur_x;
                pend_pal[i]   <= cur_pal;
                pend_valid[i] <= 1'b1;
              end
            end
            vc <= vc + VC_W'(1);
            if (ac == LAST_ATTR) begin
              state <= DONE;
            end else begin
              ac            <= ac + 6'd1;
              bus.attr_addr <= ac + 6'd1;
              state         <= FETCH_A;
            end
          end
          DONE: if (bus.hcount == H_COMMIT) begin
            act_valid         <= pend_valid;
            act_row           <= pend_row;
            act_x             <= pend_x;
            act_pal           <= pend_pal;
            bus.line_overflow <= pend_ovf;
            if (pend_ovf) bus.frame_overflow <= 1'b1;
            state             <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [9:0]  px;
  logic [10:0] col;
  logic [1:0]  pix;
  logic [5:0]  disp;

  assign px = bus.hcount[10:1];

  // Priority mux: scan from highest slot down so the lowest contributor lands last
  always_comb begin
    disp = '0;
    col  = '0;
    pix  = '0;
    for (int i = int'(MAX_SPRITES) - 1; i >= 0; i--) begin
      col = {1'b0, px} - {1'b0, act_x[i]};
      pix = act_row[i][{col[3:0], 1'b0} +: 2];
      if (act_valid[i] && col < 11'd16 && pix != 2'b00) disp = {act_pal[i], pix};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.pix_color <= '0;
    else       bus.pix_color <= (bus.hcount < H_EVAL && bus.vcount < 10'd480) ? disp : 6'd0;
  end
endmodule
